// File: rtl/hit_scan_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hit_scan_pkg : shared constants and FSM state codes for the scan |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package hit_scan_pkg;

   localparam int c_NCH_DEFAULT   = 24;
   localparam int c_CNT_W_DEFAULT = 20;
   localparam int c_WIN_W_DEFAULT = 8;

   typedef logic [2:0] state_t;

   localparam state_t c_ST_IDLE   = 3'd0;
   localparam state_t c_ST_SEEK   = 3'd1;
   localparam state_t c_ST_ARM    = 3'd2;
   localparam state_t c_ST_COUNT  = 3'd3;
   localparam state_t c_ST_REPORT = 3'd4;
   localparam state_t c_ST_DONE   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/hit_scan_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hit_scan_controller_if : result valid/ready bus of the scanner   |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface hit_scan_controller_if
   import hit_scan_pkg::*;
#(
   parameter int NCH   = c_NCH_DEFAULT,
   parameter int CNT_W = c_CNT_W_DEFAULT
);
   localparam int CH_W = $clog2(NCH);

   logic             res_valid;
   logic             res_ready;
   logic [CH_W-1:0]  res_chan;
   logic [CNT_W-1:0] res_count;
   logic             res_sat;

   modport master (output res_valid, res_chan, res_count, res_sat, input res_ready);
   modport slave  (input res_valid, res_chan, res_count, res_sat, output res_ready);

endinterface
`default_nettype wire

// File: rtl/hit_window_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hit_window_counter : saturating hit counter and window tick count|
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module hit_window_counter
   import hit_scan_pkg::*;
#(
   parameter int CNT_W = c_CNT_W_DEFAULT,
   parameter int WIN_W = c_WIN_W_DEFAULT
) (
   input  wire logic             clk40M,
   input  wire logic             reset,
   input  wire logic             clear,
   input  wire logic             enable,
   input  wire logic             hit,
   input  wire logic             tick,
   input  wire logic [WIN_W-1:0] win,
   output logic      [CNT_W-1:0] count,
   output logic                  sat,
   output logic                  win_end
);

   logic [CNT_W-1:0] r_count;
   logic             r_sat;
   logic [WIN_W-1:0] r_tick_cnt;

   // win is never zero here: the controller latches 0 as 1
   assign win_end = enable && tick && (r_tick_cnt == (win - WIN_W'(1)));
   assign count   = r_count;
   assign sat     = r_sat;

   always_ff @(posedge clk40M or posedge reset) begin
      if (reset) begin
         r_count    <= '0;
         r_sat      <= 1'b0;
         r_tick_cnt <= '0;
      end else if (clear) begin
         r_count    <= '0;
         r_sat      <= 1'b0;
         r_tick_cnt <= '0;
      end else if (enable) begin
         if (hit) begin
            if (&r_count)
               r_sat <= 1'b1;
            else
               r_count <= r_count + CNT_W'(1);
         end
         if (tick && !win_end)
            r_tick_cnt <= r_tick_cnt + WIN_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/hit_scan_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hit_scan_controller : walks masked channels, counts hits per     |
// | tick window and hands each result out over valid/ready.          |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module hit_scan_controller
   import hit_scan_pkg::*;
#(
   parameter int NCH   = c_NCH_DEFAULT,
   parameter int CNT_W = c_CNT_W_DEFAULT,
   parameter int WIN_W = c_WIN_W_DEFAULT
) (
   input  wire logic             clk40M,
   input  wire logic             reset,
   input  wire logic             tick,
   input  wire logic [NCH-1:0]   hit,
   input  wire logic             scan_start,
   input  wire logic             scan_abort,
   input  wire logic [NCH-1:0]   chan_mask,
   input  wire logic [WIN_W-1:0] win_ticks,
   output logic                  busy,
   output logic                  scan_done,
   hit_scan_controller_if.master res
);

   localparam int                CH_W        = $clog2(NCH);
   localparam logic [CH_W-1:0]   c_LAST_CHAN = CH_W'(NCH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [CH_W-1:0]  r_chan;
   logic [NCH-1:0]   r_mask;
   logic [NCH-1:0]   r_hit;
   logic [WIN_W-1:0] r_win;
   logic             r_start_d;
   logic             w_start_evt;
   logic             w_last;
   logic             w_win_end;
   logic [CNT_W-1:0] w_count;
   logic             w_sat;

   assign w_start_evt = scan_start && !r_start_d;
   assign w_last      = (r_chan == c_LAST_CHAN);

   always_comb begin
      w_next = r_state;
      if (scan_abort) begin
         w_next = c_ST_IDLE;
      end else begin
         case (r_state)
            c_ST_IDLE:   if (w_start_evt) w_next = c_ST_SEEK;
            c_ST_SEEK: begin
               if (r_mask[r_chan])
                  w_next = c_ST_ARM;
               else if (w_last)
                  w_next = c_ST_DONE;
            end
            c_ST_ARM:    if (tick) w_next = c_ST_COUNT;
            c_ST_COUNT:  if (w_win_end) w_next = c_ST_REPORT;
            c_ST_REPORT: if (res.res_ready) w_next = w_last ? c_ST_DONE : c_ST_SEEK;
            c_ST_DONE:   w_next = c_ST_IDLE;
            default:     w_next = c_ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk40M or posedge reset) begin
      if (reset) begin
         r_state   <= c_ST_IDLE;
         r_chan    <= '0;
         r_mask    <= '0;
         r_win     <= '0;
         r_hit     <= '0;
         r_start_d <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_hit     <= hit;
         r_start_d <= scan_start;
         if (!scan_abort) begin
            case (r_state)
               c_ST_IDLE: begin
                  if (w_start_evt) begin
                     r_mask <= chan_mask;
                     r_win  <= (win_ticks == '0) ? WIN_W'(1) : win_ticks;
                     r_chan <= '0;
                  end
               end
               c_ST_SEEK:   if (!r_mask[r_chan] && !w_last) r_chan <= r_chan + CH_W'(1);
               c_ST_REPORT: if (res.res_ready && !w_last) r_chan <= r_chan + CH_W'(1);
               default: ;
            endcase
         end
      end
   end

   hit_window_counter #(
      .CNT_W (CNT_W),
      .WIN_W (WIN_W)
   ) u_window (
      .clk40M  (clk40M),
      .reset   (reset),
      .clear   ((r_state == c_ST_ARM) && tick),
      .enable  (r_state == c_ST_COUNT),
      .hit     (r_hit[r_chan]),
      .tick    (tick),
      .win     (r_win),
      .count   (w_count),
      .sat     (w_sat),
      .win_end (w_win_end)
   );

   // abort must win over a same-cycle handshake or done pulse
   assign busy          = (r_state != c_ST_IDLE);
   assign scan_done     = (r_state == c_ST_DONE) && !scan_abort;
   assign res.res_valid = (r_state == c_ST_REPORT) && !scan_abort;
   assign res.res_chan  = r_chan;
   assign res.res_count = w_count;
   assign res.res_sat   = w_sat;

endmodule
`default_nettype wire
